// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
//
// Front-end fetch stage. Owns the program counter, issues one word-addressed
// fetch per cycle to instruction memory over a valid/ready handshake, and
// buffers returned instructions (tagged with their PC) in a small in-order
// queue that feeds decode. A taken redirect reloads the PC, flushes the queue
// and marks every still-outstanding response for discard.
//
// Optional feature: define FETCH_PERF_CNT_EN to add the saturating
// perf_redirects / perf_drops counters and their output ports.
//
// Ports
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   redirect_valid/pc : taken branch/jump and its target
//   imem_req_*        : fetch request (valid/ready/addr)
//   imem_resp_*       : in-order fetch response (always accepted)
//   dec_*             : queue head towards decode (valid/ready/instr/pc)
//   perf_redirects    : redirect cycles       (FETCH_PERF_CNT_EN only)
//   perf_drops        : discarded responses   (FETCH_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module fetch_pc_unit #(
  parameter int              PC_W     = 36,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [PC_W-1:0]    dec_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_redirects,
  output logic [31:0]        perf_drops
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W:0]   CREDIT_MX = (CNT_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PC_W-1:0]  PC_ONE    = PC_W'(1);

  // Architectural state
  logic [PC_W-1:0]  fetch_pc;
  logic [PC_W-1:0]  resp_pc;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Queue storage
  logic [PC_W-1:0]    q_pc    [DEPTH];
  logic [INSTR_W-1:0] q_instr [DEPTH];

  // Per-cycle events
  logic             req_fire;
  logic             drop;
  logic             enq;
  logic             deq;
  logic [CNT_W:0]   credit_used;

  // Credits cover both outstanding fetches and queued entries. Responses
  // already marked for discard will never occupy the queue, so they are
  // returned early. A pop frees its credit only from the following cycle,
  // which keeps dec_ready off the request path.
  // NOTE: every signal driven from always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    credit_used    = {1'b0, inflight} - {1'b0, drop_cnt} + {1'b0, count};
    imem_req_valid = 1'b0;
    if (!rst && !redirect_valid && (credit_used < CREDIT_MX)) begin
      imem_req_valid = 1'b1;
    end
    imem_req_addr = fetch_pc;

    req_fire = imem_req_valid && imem_req_ready;
    drop     = imem_resp_valid && (drop_cnt != '0);
    // A response landing in the redirect cycle belongs to the old path.
    enq      = imem_resp_valid && !drop && !redirect_valid;
    deq      = dec_valid && dec_ready && !redirect_valid;
  end

  // Outputs read as zero whenever the queue is empty (including reset).
  always_comb begin
    dec_valid = (count != '0);
    dec_pc    = '0;
    dec_instr = '0;
    if (dec_valid) begin
      dec_pc    = q_pc[rd_ptr];
      dec_instr = q_instr[rd_ptr];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of process order.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      // inflight tracks the memory regardless of redirects: responses
      // still arrive for abandoned fetches and must be accounted for.
      if (req_fire && !imem_resp_valid) begin
        inflight <= inflight + CNT_ONE;
      end else if (!req_fire && imem_resp_valid) begin
        inflight <= inflight - CNT_ONE;
      end

      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        // Everything still outstanding after this cycle is old-path.
        drop_cnt <= inflight - CNT_W'(imem_resp_valid);
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + PC_ONE;
        end
        if (drop) begin
          drop_cnt <= drop_cnt - CNT_ONE;
        end
        if (enq) begin
          wr_ptr  <= wr_ptr + PTR_ONE;
          resp_pc <= resp_pc + PC_ONE;
        end
        if (deq) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        if (enq && !deq) begin
          count <= count + CNT_ONE;
        end else if (!enq && deq) begin
          count <= count - CNT_ONE;
        end
      end
    end
  end

  // NOTE: the queue payload is deliberately not reset; it is only ever
  // observed through dec_valid, and count is reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_pc[wr_ptr]    <= resp_pc;
      q_instr[wr_ptr] <= imem_resp_data;
    end
  end

  // The credit scheme must make overflow impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    enq |-> (count != CNT_FULL));

`ifdef FETCH_PERF_CNT_EN
  logic discard;
  assign discard = imem_resp_valid && (drop || redirect_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_redirects <= '0;
      perf_drops     <= '0;
    end else begin
      if (redirect_valid && (perf_redirects != '1)) begin
        perf_redirects <= perf_redirects + 32'd1;
      end
      if (discard && (perf_drops != '1)) begin
        perf_drops <= perf_drops + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_unit
//
// Directed bench for fetch_pc_unit. A behavioural instruction memory answers
// accepted fetches in order after a programmable latency with data derived
// from the address. Inputs change at negedge+2 (main) and negedge+1 (memory
// response); the memory samples request/dequeue handshakes at negedge+4.
// -----------------------------------------------------------------------------
module tb_fetch_pc_unit;

  localparam int PC_W    = 36;
  localparam int INSTR_W = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               redirect_valid = 1'b0;
  logic [PC_W-1:0]    redirect_pc = '0;
  logic               imem_req_valid;
  logic               imem_req_ready = 1'b1;
  logic [PC_W-1:0]    imem_req_addr;
  logic               imem_resp_valid = 1'b0;
  logic [INSTR_W-1:0] imem_resp_data = '0;
  logic               dec_valid;
  logic               dec_ready = 1'b1;
  logic [INSTR_W-1:0] dec_instr;
  logic [PC_W-1:0]    dec_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]        perf_redirects;
  logic [31:0]        perf_drops;
`endif

  always #5 clk = ~clk;

  fetch_pc_unit #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W),
    .RESET_PC('0),
    .DEPTH   (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_redirects (perf_redirects),
    .perf_drops     (perf_drops)
`endif
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Memory model state
  int              mem_lat     = 1;
  int              neg_cnt     = 0;
  int              outstanding = 0;
  logic [PC_W-1:0] pend_addr[$];
  int              pend_due[$];

  function automatic logic [INSTR_W-1:0] instr_of(input logic [PC_W-1:0] a);
    return a[31:0] ^ 32'hDEAD_BEEF ^ {a[35:32], 28'h0};
  endfunction

  always @(negedge clk) begin
    neg_cnt++;
    #1;
    if (rst) begin
      pend_addr.delete();
      pend_due.delete();
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      outstanding     = 0;
    end else if (pend_due.size() != 0 && pend_due[0] <= neg_cnt) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = instr_of(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
    #3;
    if (!rst) begin
      if (imem_req_valid && imem_req_ready) begin
        pend_addr.push_back(imem_req_addr);
        pend_due.push_back(neg_cnt + mem_lat);
        outstanding++;
      end
      if (dec_valid && dec_ready && !redirect_valid) outstanding--;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  // Wait (bounded) for the next head, check it, and let it be consumed.
  task automatic expect_dec(input string tag, input logic [PC_W-1:0] pc);
    int n = 0;
    while (!dec_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, "_valid"}, 64'(dec_valid), 64'd1);
    check({tag, "_pc"},    64'(dec_pc),    64'(pc));
    check({tag, "_instr"}, 64'(dec_instr), 64'(instr_of(pc)));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int peak;
    int exp_drop;

    // ---- Reset values -------------------------------------------------------
    step();
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_req_addr",  64'(imem_req_addr),  64'd0);
    check("rst_dec_valid", 64'(dec_valid),      64'd0);
    check("rst_dec_pc",    64'(dec_pc),         64'd0);
    check("rst_dec_instr", 64'(dec_instr),      64'd0);
    step();
    rst = 1'b0;
    #1;
    check("first_req_valid", 64'(imem_req_valid), 64'd1);
    check("first_req_addr",  64'(imem_req_addr),  64'd0);

    // ---- Reset fetch: request, 1-cycle memory, registered queue ------------
    step();
    step();
    check("first_dec_latency", 64'(dec_valid), 64'd1);
    expect_dec("seq0", 36'h0);
    expect_dec("seq1", 36'h1);
    expect_dec("seq2", 36'h2);
    expect_dec("seq3", 36'h3);

    // ---- Backpressure -------------------------------------------------------
    dec_ready = 1'b0;
    peak = outstanding;
    for (int i = 0; i < 5; i++) begin
      step();
      if (outstanding > peak) peak = outstanding;
    end
    check("bp_req_valid", 64'(imem_req_valid), 64'd0);
    check("bp_head_pc",   64'(dec_pc),         64'h4);
    check("bp_peak",      64'(peak),           64'd2);
    dec_ready = 1'b1;
    expect_dec("bp0", 36'h4);
    expect_dec("bp1", 36'h5);
    expect_dec("bp2", 36'h6);

    // ---- Redirect with two fetches in flight (3-cycle memory) --------------
    mem_lat = 3;
    n = 0;
    while (!(pend_addr.size() == 2 && !imem_resp_valid) && n < 40) begin
      step();
      n++;
    end
    check("rd_two_inflight", 64'(pend_addr.size()), 64'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 36'h100;
    step();
    redirect_valid = 1'b0;
    #1;
    check("rd_req_valid", 64'(imem_req_valid), 64'd1);
    check("rd_req_addr",  64'(imem_req_addr),  64'h100);
    check("rd_dec_valid", 64'(dec_valid),      64'd0);
    check("rd_drop_cnt",  64'(dut.drop_cnt),   64'd2);
    expect_dec("rd0", 36'h100);
    expect_dec("rd1", 36'h101);

    // ---- Redirect coinciding with a response --------------------------------
    n = 0;
    while (!(imem_resp_valid && pend_addr.size() >= 1) && n < 40) begin
      step();
      n++;
    end
    check("sim_found", 64'(imem_resp_valid), 64'd1);
    exp_drop       = pend_addr.size();
    redirect_valid = 1'b1;
    redirect_pc    = 36'h180;
    step();
    redirect_valid = 1'b0;
    #1;
    check("sim_drop_cnt",  64'(dut.drop_cnt), 64'(exp_drop));
    check("sim_dec_valid", 64'(dec_valid),    64'd0);
    expect_dec("sim0", 36'h180);

    // ---- Back-to-back redirects --------------------------------------------
    redirect_valid = 1'b1;
    redirect_pc    = 36'h200;
    step();
    redirect_pc    = 36'h300;
    step();
    redirect_valid = 1'b0;
    expect_dec("b2b0", 36'h300);
    expect_dec("b2b1", 36'h301);

    // ---- PC wrap-around ------------------------------------------------------
    mem_lat        = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 36'hF_FFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    #1;
    check("wrap_req_addr", 64'(imem_req_addr), 64'hF_FFFF_FFFF);
    expect_dec("wrap0", 36'hF_FFFF_FFFF);
    expect_dec("wrap1", 36'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Front-end fetch stage that owns the program counter and feeds the decode pipeline, including `branch_jump_decoder`. Each cycle it issues a 36-bit word-addressed fetch to instruction memory over a valid/ready handshake. It buffers returned instructions, tagged with their PC, in a small in-order fetch queue. When the branch/jump path reports a taken redirect (`pc_next` differs from sequential flow), it loads the new PC, flushes the queue and discards responses that are still in flight.

## Interface
- `PC_W`, 36: PC and address width.
- `INSTR_W`, 32: instruction width.
- `RESET_PC`, 36'h0: PC loaded on reset.
- `DEPTH`, 2: fetch-queue entries; also the cap on in-flight plus buffered fetches (power of two, ≥2).

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `redirect_valid` in 1: taken branch/jump this cycle.
- `redirect_pc` in PC_W: target (`pc_next` from `branch_jump_decoder`).
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts request.
- `imem_req_addr` out PC_W: fetch address.
- `imem_resp_valid` in 1: response valid, in order, ≥1 cycle after acceptance, always accepted.
- `imem_resp_data` in INSTR_W: fetched instruction.
- `dec_valid` out 1: queue head valid.
- `dec_ready` in 1: decode consumes head.
- `dec_instr` out INSTR_W: head instruction.
- `dec_pc` out PC_W: head PC.

## Operation
- **State registers**
  - `fetch_pc`: next address to request.
  - `resp_pc`: PC of the next expected response.
  - `inflight`: accepted requests not yet answered, 0..DEPTH.
  - `drop_cnt`: in-flight responses to discard.
  - Queue: circular buffer of {pc, instr} with read/write pointers and a count.
- **Request issue**
  - `imem_req_valid` = !rst_q && !redirect_valid && (inflight − drop_cnt + count) < DEPTH.
  - `imem_req_addr` = `fetch_pc`.
  - On accept (valid && ready): `fetch_pc` += 1 (wraps modulo 2^PC_W); `inflight` += 1.
  - `imem_req_valid` and `imem_req_addr` hold stable until accepted, unless a redirect occurs.
- **Response**
  - Each `imem_resp_valid` decrements `inflight`.
  - If `drop_cnt` > 0: discard the data and decrement `drop_cnt`.
  - Otherwise enqueue {`resp_pc`, `imem_resp_data`} and increment `resp_pc`.
  - The credit rule above guarantees the queue never overflows. An enqueue into a full queue is an assertion failure.
- **Dequeue**: when `dec_valid && dec_ready`, pop the head. Enqueue and dequeue in the same cycle leaves count unchanged.
- **Redirect** (highest priority)
  - `fetch_pc` and `resp_pc` ← `redirect_pc`.
  - Queue is cleared; any dequeue that cycle is ignored.
  - `drop_cnt` ← `inflight` − `imem_resp_valid`. This counts every outstanding response, including ones already marked for drop.
  - No request is issued that cycle.
  - If a request was pending and not yet accepted, it is abandoned.
  - A redirect while `drop_cnt` > 0 recomputes `drop_cnt` by the same rule.
- **Reset**
  - `fetch_pc` = `resp_pc` = RESET_PC.
  - `inflight` = `drop_cnt` = count = 0.
  - Reset mid-operation abandons in-flight fetches. The integrating memory must also be reset.

## Timing
- **Output values during reset**: `imem_req_valid`=0, `dec_valid`=0, `imem_req_addr`=RESET_PC, `dec_pc`=0, `dec_instr`=0.
- **First request**: `imem_req_valid` rises in the first cycle after `rst` deasserts.
- **Response to decode**: a response in cycle M is visible on `dec_valid`/`dec_instr` in cycle M+1. The queue is registered; there is no bypass.
- **Redirect**: a redirect in cycle N presents `imem_req_addr`=`redirect_pc` with `imem_req_valid`=1 in N+1, and `dec_valid`=0 in N+1.
- **Throughput**: with 1-cycle memory, DEPTH=2 and `dec_ready` held at 1, one instruction reaches decode per cycle in steady state.
- **Combinational paths**: none from `dec_ready` or `imem_req_ready` to any output.

## Configuration
- **`FETCH_PERF_CNT_EN` defined**: adds outputs `perf_redirects` (32) and `perf_drops` (32).
  - `perf_redirects` counts redirect cycles.
  - `perf_drops` counts discarded responses.
  - Both are zero on reset and saturate at all-ones.
- **Not defined**: the ports and counters are absent, and all other behaviour is identical.

## Test plan
- **Reset fetch**: `rst` 2 cycles, then memory with 1-cycle latency and `dec_ready`=1 → `dec_pc` sequence 0,1,2,3 on consecutive cycles, with `dec_instr` matching memory contents.
- **Backpressure**: `dec_ready`=0 for 5 cycles → queue fills to 2, `imem_req_valid` drops, and `inflight`+count never exceeds 2. Releasing `dec_ready` delivers PCs in order with no loss or duplication.
- **Redirect with 2 in flight**: 3-cycle memory latency, redirect to 36'h100 → the next two responses are discarded, then `dec_pc`=36'h100, 36'h101.
- **Simultaneous events**: redirect coincides with `imem_resp_valid` and `dec_ready`=1 → the response is not enqueued, `drop_cnt`=`inflight`−1, and `dec_valid`=0 next cycle.
- **Back-to-back redirects**: redirect to 36'h200, then the next cycle to 36'h300 → only 36'h300 onward reaches decode.
- **Wrap-around**: redirect to 36'hF_FFFF_FFFF → next `dec_pc` values are 36'hF_FFFF_FFFF then 36'h0.
